seg_pipe_skid: RTL

Parametrised, elastic pipeline segment: the next-generation execute-to-memory stage register for the RSA pipeline CPU. It carries the PCSrc/RegWrite/MemtoReg/MemWrite control bits, ALU result, store data and destination register between stages. It adds a valid/ready handshake, a two-entry skid buffer so backpressure never drops a beat, and a synchronous flush for branch squash. Generic widths let the same block serve EX/MEM and MEM/WB.

---
 rtl/seg_pipe_skid_pkg.sv | 25 ++
 rtl/seg_pipe_skid_if.sv | 45 ++++
 rtl/seg_pipe_skid_entry_reg.sv | 38 +++
 rtl/seg_pipe_skid.sv | 130 +++++++++++++
 4 files changed

// File: rtl/seg_pipe_skid_pkg.sv
// Shared types and constants for the seg_pipe_skid elastic pipeline segment.
// Optional feature macro: SEG_FWD_EN (forwarding-hit flags on the top level).
package seg_pkg;

    // Number of control bits carried with every beat.
    localparam int CTRL_W     = 4;

    // Default datapath widths (EX/MEM usage in the RSA pipeline CPU).
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 4;

    // Control bits from the execute stage, MSB first.
    typedef struct packed {
        logic pcsrc;
        logic regwrite;
        logic memtoreg;
        logic memwrite;
    } ctrl_t;

    // Total payload width of one held entry: control, ALU result, store data, WA3.
    function automatic int payload_w(input int data_w, input int addr_w);
        return CTRL_W + 2 * data_w + addr_w;
    endfunction

endpackage

// File: rtl/seg_pipe_skid_if.sv
// Handshake and payload bundle for seg_pipe_skid: upstream (in_*) and downstream (out_*).
// slave modport is the segment itself; master modport is the surrounding environment.
interface seg_pipe_skid_if
    import seg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    // Upstream side
    logic              in_valid;
    logic              in_ready;
    logic              pcsrc_i;
    logic              regwrite_i;
    logic              memtoreg_i;
    logic              memwrite_i;
    logic [DATA_W-1:0] alu_result_i;
    logic [DATA_W-1:0] write_data_i;
    logic [ADDR_W-1:0] wa3_i;

    // Downstream side
    logic              out_valid;
    logic              out_ready;
    logic              pcsrc_o;
    logic              regwrite_o;
    logic              memtoreg_o;
    logic              memwrite_o;
    logic [DATA_W-1:0] alu_out_o;
    logic [DATA_W-1:0] write_data_o;
    logic [ADDR_W-1:0] wa3_o;

    modport slave (
        input  in_valid, pcsrc_i, regwrite_i, memtoreg_i, memwrite_i,
               alu_result_i, write_data_i, wa3_i, out_ready,
        output in_ready, out_valid, pcsrc_o, regwrite_o, memtoreg_o, memwrite_o,
               alu_out_o, write_data_o, wa3_o
    );

    modport master (
        output in_valid, pcsrc_i, regwrite_i, memtoreg_i, memwrite_i,
               alu_result_i, write_data_i, wa3_i, out_ready,
        input  in_ready, out_valid, pcsrc_o, regwrite_o, memtoreg_o, memwrite_o,
               alu_out_o, write_data_o, wa3_o
    );

endinterface

// File: rtl/seg_pipe_skid_entry_reg.sv
// seg_entry_reg: one valid bit plus a payload register with load and clear.
// Clear drops the valid bit but keeps the payload, so outputs hold their last value.
module seg_entry_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Valid/payload update: reset beats clear, clear beats load.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for every register so all state in the
        // segment updates from the same pre-edge values.
        if (rst) begin
            r_valid <= 1'b0;
            // NOTE: the payload is reset too, because data outputs must read zero
            // after reset; this is a small register, not a memory array.
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/seg_pipe_skid.sv
// seg_pipe_skid: elastic EX/MEM (or MEM/WB) stage register with a two-entry skid buffer.
// Main entry drives the outputs; skid absorbs the one beat accepted while main stalls.
// Optional feature macro: SEG_FWD_EN adds ra1_i/ra2_i and fwd_a_o/fwd_b_o hit flags.
module seg_pipe_skid
    import seg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
`ifdef SEG_FWD_EN
    input  logic [ADDR_W-1:0] ra1_i,
    input  logic [ADDR_W-1:0] ra2_i,
    output logic              fwd_a_o,
    output logic              fwd_b_o,
`endif
    seg_pipe_skid_if.slave    bus
);

    localparam int ENTRY_W = payload_w(DATA_W, ADDR_W);

    typedef struct packed {
        ctrl_t             ctrl;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] wdata;
        logic [ADDR_W-1:0] wa3;
    } payload_t;

    payload_t w_in_payload;
    payload_t w_main_d;
    payload_t w_main_q;
    payload_t w_skid_q;

    logic w_main_valid;
    logic w_skid_valid;
    logic w_accept;
    logic w_drain;
    logic w_main_open;
    logic w_main_load;
    logic w_main_clear;
    logic w_main_sel_skid;
    logic w_skid_load;
    logic w_skid_clear;

    assign w_in_payload = '{
        ctrl:  '{pcsrc:    bus.pcsrc_i,
                 regwrite: bus.regwrite_i,
                 memtoreg: bus.memtoreg_i,
                 memwrite: bus.memwrite_i},
        alu:   bus.alu_result_i,
        wdata: bus.write_data_i,
        wa3:   bus.wa3_i
    };

    // Ready depends only on the registered skid valid bit, never on out_ready.
    assign bus.in_ready = !w_skid_valid;
    assign w_accept     = bus.in_valid && !w_skid_valid;
    assign w_drain      = w_main_valid && bus.out_ready;
    assign w_main_open  = !w_main_valid || w_drain;

    // Entry steering: flush wins, then refill main (skid first), else park input in skid.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave a signal unassigned and infer a latch.
        w_main_load     = 1'b0;
        w_main_clear    = 1'b0;
        w_main_sel_skid = 1'b0;
        w_skid_load     = 1'b0;
        w_skid_clear    = 1'b0;
        if (flush) begin
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else if (w_main_open) begin
            if (w_skid_valid) begin
                // Skid moves to main; input cannot be accepted since in_ready is low.
                w_main_load     = 1'b1;
                w_main_sel_skid = 1'b1;
                w_skid_clear    = 1'b1;
            end else if (w_accept) begin
                w_main_load = 1'b1;
            end else begin
                w_main_clear = 1'b1;
            end
        end else if (w_accept) begin
            // Main stalled and skid empty (implied by w_accept): absorb the beat.
            w_skid_load = 1'b1;
        end
    end

    assign w_main_d = w_main_sel_skid ? w_skid_q : w_in_payload;

    seg_entry_reg #(.W(ENTRY_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_data  (w_main_d),
        .o_valid (w_main_valid),
        .o_data  (w_main_q)
    );

    seg_entry_reg #(.W(ENTRY_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (w_in_payload),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_q)
    );

    // Control bits are gated by out_valid so a bubble never writes memory or registers.
    assign bus.out_valid    = w_main_valid;
    assign bus.pcsrc_o      = w_main_valid && w_main_q.ctrl.pcsrc;
    assign bus.regwrite_o   = w_main_valid && w_main_q.ctrl.regwrite;
    assign bus.memtoreg_o   = w_main_valid && w_main_q.ctrl.memtoreg;
    assign bus.memwrite_o   = w_main_valid && w_main_q.ctrl.memwrite;
    assign bus.alu_out_o    = w_main_q.alu;
    assign bus.write_data_o = w_main_q.wdata;
    assign bus.wa3_o        = w_main_q.wa3;

`ifdef SEG_FWD_EN
    // Forwarding hits come straight from held main-entry state.
    assign fwd_a_o = w_main_valid && w_main_q.ctrl.regwrite && (w_main_q.wa3 == ra1_i);
    assign fwd_b_o = w_main_valid && w_main_q.ctrl.regwrite && (w_main_q.wa3 == ra2_i);
`endif

endmodule
